// File: rtl/multi_counter_sat.sv
// Bank of CNTRS_N independent counters held in a dual-port RAM, updated by a
// pipelined command stream with per-id forwarding so back-to-back ops see fresh values.
module multi_counter_sat #(
  parameter int CNTRS_N    = 256,
  parameter int CNTRS_W    = 32,
  parameter int SAT_EN     = 0,
  parameter int CNTRS_ID_W = $clog2(CNTRS_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [CNTRS_ID_W-1:0] cmd_id,
  input  logic [2:0]            cmd_op,
  input  logic [CNTRS_W-1:0]    cmd_dat,
  output logic                  status_vld_r,
  output logic                  status_qry_r,
  output logic [CNTRS_ID_W-1:0] status_id_r,
  output logic [CNTRS_W-1:0]    status_dat_r,
  output logic                  status_ovf_r
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INIT  = 3'd1,
    OP_INCR  = 3'd2,
    OP_DECR  = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_QUERY = 3'd6,
    OP_RDCLR = 3'd7
  } op_e;

  typedef enum logic {ST_CLR, ST_RUN} state_e;

  typedef struct packed {
    logic                  vld;
    logic                  qry;
    logic                  ovf;
    logic [CNTRS_ID_W-1:0] id;
    logic [CNTRS_W-1:0]    val;
    logic [CNTRS_W-1:0]    res;
  } stage_t;

  localparam logic [CNTRS_ID_W-1:0] LAST_ID  = CNTRS_ID_W'(CNTRS_N - 1);
  localparam logic [CNTRS_W:0]      WIDE_ONE = (CNTRS_W + 1)'(1);

  state_e                state_q, state_d;
  logic [CNTRS_ID_W-1:0] clrIdx_q, clrIdx_d;
  logic                  sweepWr;

  logic                  accept;
  logic                  s1Vld_q;
  logic [CNTRS_ID_W-1:0] s1Id_q;
  op_e                   s1Op_q;
  logic [CNTRS_W-1:0]    s1Dat_q;

  logic [CNTRS_W-1:0]    mem [CNTRS_N];
  logic [CNTRS_W-1:0]    rdData_q;
  logic                  wrEn;
  logic [CNTRS_ID_W-1:0] wrAddr;
  logic [CNTRS_W-1:0]    wrData;

  logic [CNTRS_W-1:0]    oldVal;
  logic [CNTRS_W-1:0]    newVal;
  logic [CNTRS_W-1:0]    resVal;
  logic [CNTRS_W:0]      wide;
  logic                  arith;
  logic                  isSub;
  logic                  ovf;
  logic                  qry;

  stage_t                s2_d, s2_q, s3_q, s4_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CLR;
      clrIdx_q <= '0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    sweepWr  = 1'b0;
    if (state_q == ST_CLR) begin
      sweepWr = 1'b1;
      if (clrIdx_q == LAST_ID) begin
        state_d = ST_RUN;
      end else begin
        clrIdx_d = clrIdx_q + CNTRS_ID_W'(1);
      end
    end
  end

  assign cmd_rdy = (state_q == ST_RUN) && !rst;
  assign accept  = cmd_vld && cmd_rdy && (cmd_op != OP_NOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Vld_q <= 1'b0;
      s1Id_q  <= '0;
      s1Op_q  <= OP_NOP;
      s1Dat_q <= '0;
    end else begin
      s1Vld_q <= accept;
      s1Id_q  <= cmd_id;
      s1Op_q  <= op_e'(cmd_op);
      s1Dat_q <= cmd_dat;
    end
  end

  // Writes come from the sweep or from stage 2; a same-edge write to the address
  // being read is bypassed so the read never returns the pre-write value.
  assign wrEn   = !rst && (sweepWr || s2_q.vld);
  assign wrAddr = sweepWr ? clrIdx_q : s2_q.id;
  assign wrData = sweepWr ? '0 : s2_q.val;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    if (wrEn && (wrAddr == cmd_id)) begin
      rdData_q <= wrData;
    end else begin
      rdData_q <= mem[cmd_id];
    end
  end

  always_comb begin
    oldVal = rdData_q;
    if (s4_q.vld && (s4_q.id == s1Id_q)) oldVal = s4_q.val;
    if (s3_q.vld && (s3_q.id == s1Id_q)) oldVal = s3_q.val;
    if (s2_q.vld && (s2_q.id == s1Id_q)) oldVal = s2_q.val;
  end

  // Arithmetic is done one bit wider so the carry/borrow bit flags overflow.
  always_comb begin
    wide   = {1'b0, oldVal};
    arith  = 1'b0;
    isSub  = 1'b0;
    ovf    = 1'b0;
    qry    = 1'b0;
    newVal = oldVal;
    resVal = oldVal;
    case (s1Op_q)
      OP_INIT: begin
        newVal = s1Dat_q;
        resVal = s1Dat_q;
      end
      OP_INCR: begin
        wide  = {1'b0, oldVal} + WIDE_ONE;
        arith = 1'b1;
      end
      OP_DECR: begin
        wide  = {1'b0, oldVal} - WIDE_ONE;
        arith = 1'b1;
        isSub = 1'b1;
      end
      OP_ADD: begin
        wide  = {1'b0, oldVal} + {1'b0, s1Dat_q};
        arith = 1'b1;
      end
      OP_SUB: begin
        wide  = {1'b0, oldVal} - {1'b0, s1Dat_q};
        arith = 1'b1;
        isSub = 1'b1;
      end
      OP_QUERY: qry = 1'b1;
      OP_RDCLR: begin
        qry    = 1'b1;
        newVal = '0;
      end
      default: ;
    endcase
    if (arith) begin
      ovf = wide[CNTRS_W];
      if (ovf && (SAT_EN != 0)) begin
        newVal = isSub ? '0 : '1;
      end else begin
        newVal = wide[CNTRS_W-1:0];
      end
      resVal = newVal;
    end
  end

  always_comb begin
    s2_d     = '0;
    s2_d.vld = s1Vld_q;
    s2_d.qry = qry;
    s2_d.ovf = ovf;
    s2_d.id  = s1Id_q;
    s2_d.val = newVal;
    s2_d.res = resVal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
    end else begin
      s2_q <= s2_d;
      s3_q <= s2_q;
      s4_q <= s3_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_vld_r <= 1'b0;
      status_qry_r <= 1'b0;
      status_ovf_r <= 1'b0;
      status_id_r  <= '0;
      status_dat_r <= '0;
    end else begin
      status_vld_r <= s4_q.vld;
      status_qry_r <= s4_q.vld && s4_q.qry;
      status_ovf_r <= s4_q.vld && s4_q.ovf;
      status_id_r  <= s4_q.id;
      status_dat_r <= s4_q.res;
    end
  end

endmodule

// File: tb/tb_multi_counter_sat.sv
// Self-checking bench for multi_counter_sat: a wrapping and a saturating instance
// share one command stream; expected results are queued per instance and popped on status.
module tb_multi_counter_sat;

  localparam int N = 8;
  localparam int W = 8;

  typedef struct {
    int         due;
    logic [2:0] id;
    logic [7:0] dat;
    logic       ovf;
    logic       qry;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [2:0] id;
    logic [7:0] dat;
    logic [7:0] wDat;
    logic       wOvf;
    logic [7:0] sDat;
    logic       sOvf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmdVld = 1'b0;
  logic [2:0] cmdId = '0;
  logic [2:0] cmdOp = '0;
  logic [7:0] cmdDat = '0;

  logic       wRdy, wVld, wQry, wOvf;
  logic [2:0] wId;
  logic [7:0] wDat;
  logic       sRdy, sVld, sQry, sOvf;
  logic [2:0] sId;
  logic [7:0] sDat;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t qWrap[$];
  exp_t qSat[$];
  int   mdl[2][N];
  vec_t vecs[14];
  vec_t noVec;

  multi_counter_sat #(.CNTRS_N(N), .CNTRS_W(W), .SAT_EN(0)) dutWrap (
    .clk(clk), .rst(rst), .cmd_vld(cmdVld), .cmd_rdy(wRdy), .cmd_id(cmdId),
    .cmd_op(cmdOp), .cmd_dat(cmdDat), .status_vld_r(wVld), .status_qry_r(wQry),
    .status_id_r(wId), .status_dat_r(wDat), .status_ovf_r(wOvf)
  );

  multi_counter_sat #(.CNTRS_N(N), .CNTRS_W(W), .SAT_EN(1)) dutSat (
    .clk(clk), .rst(rst), .cmd_vld(cmdVld), .cmd_rdy(sRdy), .cmd_id(cmdId),
    .cmd_op(cmdOp), .cmd_dat(cmdDat), .status_vld_r(sVld), .status_qry_r(sQry),
    .status_id_r(sId), .status_dat_r(sDat), .status_ovf_r(sOvf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour: integer arithmetic, then wrap or clamp.
  task automatic modelStep(input int m, input int op, input int id, input int dat,
                           output logic [7:0] r, output logic o);
    int old;
    int res;
    old = mdl[m][id];
    o = 1'b0;
    case (op)
      1: res = dat;
      2: res = old + 1;
      3: res = old - 1;
      4: res = old + dat;
      5: res = old - dat;
      7: res = 0;
      default: res = old;
    endcase
    if (op >= 2 && op <= 5) begin
      if (res > 255) begin
        o = 1'b1;
        res = (m == 1) ? 255 : res - 256;
      end else if (res < 0) begin
        o = 1'b1;
        res = (m == 1) ? 0 : res + 256;
      end
    end
    mdl[m][id] = res;
    r = (op == 7) ? 8'(old) : 8'(res);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] id, input logic [7:0] dat,
                               input bit useVec, input vec_t v);
    exp_t e;
    logic [7:0] r;
    logic o;
    cmdVld = 1'b1;
    cmdOp  = op;
    cmdId  = id;
    cmdDat = dat;
    if (op != 3'd0) begin
      e.due = cyc + 5;
      e.id  = id;
      e.qry = (op == 3'd6) || (op == 3'd7);
      modelStep(0, int'(op), int'(id), int'(dat), r, o);
      e.dat = useVec ? v.wDat : r;
      e.ovf = useVec ? v.wOvf : o;
      qWrap.push_back(e);
      modelStep(1, int'(op), int'(id), int'(dat), r, o);
      e.dat = useVec ? v.sDat : r;
      e.ovf = useVec ? v.sOvf : o;
      qSat.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmdVld = 1'b0;
    cmdOp  = 3'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int m, input logic vld, input logic qry, input logic [2:0] id,
                             input logic [7:0] dat, input logic ovf);
    exp_t e;
    bit have;
    string t;
    t = (m == 1) ? "sat" : "wrap";
    if (m == 1) begin
      have = qSat.size() > 0;
      if (have) e = qSat[0];
    end else begin
      have = qWrap.size() > 0;
      if (have) e = qWrap[0];
    end
    if (vld === 1'b1) begin
      if (!have) begin
        cmp({t, " unexpected status"}, 32'd1, 32'd0);
      end else begin
        if (m == 1) void'(qSat.pop_front());
        else void'(qWrap.pop_front());
        cmp({t, " latency"}, cyc, e.due);
        cmp({t, " id"}, 32'(id), 32'(e.id));
        cmp({t, " dat"}, 32'(dat), 32'(e.dat));
        cmp({t, " ovf"}, 32'(ovf), 32'(e.ovf));
        cmp({t, " qry"}, 32'(qry), 32'(e.qry));
      end
    end else if (have && cyc >= e.due) begin
      cmp({t, " missing status"}, 32'd0, 32'd1);
      if (m == 1) void'(qSat.pop_front());
      else void'(qWrap.pop_front());
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, wVld, wQry, wId, wDat, wOvf);
    checkOutput(1, sVld, sQry, sId, sDat, sOvf);
  end

  task automatic waitSweep(input string name);
    int n;
    n = 0;
    while (wRdy !== 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    cmp({name, " rdy-low cycles"}, n, 8);
    cmp({name, " sat rdy"}, 32'(sRdy), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qWrap.size() + qSat.size()) > 0 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    cmp({name, " drain"}, qWrap.size() + qSat.size(), 0);
  endtask

  task automatic clearModel();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) mdl[m][i] = 0;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 3'd3, 8'hFE, 8'hFE, 1'b0, 8'hFE, 1'b0};
    vecs[1]  = '{3'd2, 3'd3, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[2]  = '{3'd2, 3'd3, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{3'd2, 3'd3, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[4]  = '{3'd3, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[5]  = '{3'd4, 3'd1, 8'h80, 8'h80, 1'b0, 8'h80, 1'b0};
    vecs[6]  = '{3'd4, 3'd2, 8'h10, 8'h10, 1'b0, 8'h10, 1'b0};
    vecs[7]  = '{3'd4, 3'd1, 8'h90, 8'h10, 1'b1, 8'hFF, 1'b1};
    vecs[8]  = '{3'd7, 3'd1, 8'h00, 8'h10, 1'b0, 8'hFF, 1'b0};
    vecs[9]  = '{3'd6, 3'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{3'd5, 3'd2, 8'h20, 8'hF0, 1'b1, 8'h00, 1'b1};
    vecs[11] = '{3'd6, 3'd0, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{3'd4, 3'd3, 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
    vecs[13] = '{3'd5, 3'd3, 8'h01, 8'h7F, 1'b0, 8'hFE, 1'b0};
    noVec = vecs[0];
    clearModel();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset wrap vld", 32'(wVld), 32'd0);
    cmp("reset wrap qry", 32'(wQry), 32'd0);
    cmp("reset wrap ovf", 32'(wOvf), 32'd0);
    cmp("reset wrap id", 32'(wId), 32'd0);
    cmp("reset wrap dat", 32'(wDat), 32'd0);
    cmp("reset sat vld", 32'(sVld), 32'd0);
    cmp("reset sat dat", 32'(sDat), 32'd0);
    cmp("reset rdy", 32'(wRdy), 32'd0);

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("mid-sweep rdy", 32'(wRdy), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitSweep("restarted sweep");

    applyStimulus(3'd6, 3'd5, 8'h00, 1'b0, noVec);
    idle();
    drain("query after sweep");

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].id, vecs[i].dat, 1'b1, vecs[i]);
    end
    idle();
    drain("vector table");

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          cmdVld = 1'b0;
          cmdOp  = 3'($urandom_range(1, 7));
          cmdId  = 3'($urandom_range(0, 7));
          @(posedge clk);
          #1;
        end
        1: applyStimulus(3'd0, 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, noVec);
        default: applyStimulus(3'($urandom_range(1, 7)), 3'($urandom_range(0, 3)),
                               8'($urandom), 1'b0, noVec);
      endcase
    end
    idle();
    drain("random stream");

    for (int i = 0; i < 3; i++) applyStimulus(3'd2, 3'd4, 8'h00, 1'b0, noVec);
    cmdVld = 1'b0;
    cmdOp  = 3'd0;
    rst    = 1'b1;
    #1;
    cmp("rdy during rst wrap", 32'(wRdy), 32'd0);
    cmp("rdy during rst sat", 32'(sRdy), 32'd0);
    qWrap.delete();
    qSat.delete();
    @(posedge clk);
    #1;
    cmp("post-rst wrap vld", 32'(wVld), 32'd0);
    cmp("post-rst sat vld", 32'(sVld), 32'd0);
    rst = 1'b0;
    waitSweep("rerun sweep");
    clearModel();
    applyStimulus(3'd6, 3'd4, 8'h00, 1'b0, noVec);
    idle();
    drain("query after rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/multi_counter_sat.md
MULTI_COUNTER_SAT -- requirements
Module: multi_counter_sat

Interface
REQ-001 SHALL have parameter CNTRS_N, default 256: number of independent counters.
REQ-002 SHALL have parameter CNTRS_W, default 32: counter width in bits.
REQ-003 SHALL have parameter SAT_EN, default 0: 0 = wrap-around arithmetic, 1 = saturating arithmetic.
REQ-004 SHALL have parameter CNTRS_ID_W, default $clog2(CNTRS_N): counter index width.
REQ-005 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port cmd_vld, input, 1: command present this cycle.
REQ-008 SHALL have port cmd_rdy, output, 1: block accepts a command this cycle.
REQ-009 SHALL have port cmd_id, input, CNTRS_ID_W: target counter.
REQ-010 SHALL have port cmd_op, input, 3: opcode; 0 NOP, 1 INIT, 2 INCR, 3 DECR, 4 ADD, 5 SUB, 6 QUERY, 7 RDCLR.
REQ-011 SHALL have port cmd_dat, input, CNTRS_W: INIT value or ADD/SUB operand.
REQ-012 SHALL have port status_vld_r, output, 1: registered result valid.
REQ-013 SHALL have port status_qry_r, output, 1: result belongs to QUERY or RDCLR.
REQ-014 SHALL have port status_id_r, output, CNTRS_ID_W: counter id of the result.
REQ-015 SHALL have port status_dat_r, output, CNTRS_W: result value.
REQ-016 SHALL have port status_ovf_r, output, 1: the operation overflowed or underflowed.

Function
REQ-017 SHALL accept a command when cmd_vld & cmd_rdy & cmd_op!=NOP; all other inputs SHALL be ignored, with no state change and no status.
REQ-018 SHALL hold counter state in a dual-port RAM of CNTRS_N x CNTRS_W, using one read port and one write port.
REQ-019 SHALL present status for an accepted command exactly 4 cycles after acceptance, and SHALL sustain a throughput of one command per cycle.
REQ-020 SHALL give results that are sequentially consistent per id, including back-to-back commands to the same id, through forwarding from every later stage and a same-cycle RAM read/write collision bypass.
REQ-021 INIT SHALL write cmd_dat; INCR/DECR SHALL add/subtract 1; ADD/SUB SHALL add/subtract cmd_dat; QUERY SHALL leave the value unchanged; RDCLR SHALL write 0.
REQ-022 status_dat_r SHALL be the post-op value for INIT, INCR, DECR, ADD, SUB and QUERY, and the pre-clear value for RDCLR.
REQ-023 SHALL compute all arithmetic at CNTRS_W+1 bits; status_ovf_r SHALL be 1 when the true result is above 2^CNTRS_W-1 or below 0, and 0 for INIT, QUERY and RDCLR.
REQ-024 With SAT_EN=0, an overflowing or underflowing result SHALL wrap modulo 2^CNTRS_W.
REQ-025 With SAT_EN=1, an overflowing result SHALL clamp to 2^CNTRS_W-1 and an underflowing result SHALL clamp to 0.
REQ-026 status_vld_r SHALL be 1 for every accepted command; status_qry_r SHALL be 1 only for QUERY and RDCLR.
REQ-027 cmd_id values of CNTRS_N or above SHALL be undefined usage; the bench SHALL not drive them.

Reset
REQ-028 On rst, status_vld_r, status_qry_r and status_ovf_r SHALL be 0 in the following cycle; status_id_r and status_dat_r SHALL be 0.
REQ-029 On rst, all in-flight commands SHALL be discarded, and none of them SHALL write the RAM.
REQ-030 Init sweep, state CLR: after rst deasserts, the block SHALL write 0 to ids 0..CNTRS_N-1, one per cycle, with cmd_rdy=0 throughout.
REQ-031 Init sweep, state RUN: after the last write, the block SHALL enter RUN and set cmd_rdy=1 from the next cycle; cmd_rdy SHALL be 0 during rst.
REQ-032 An rst asserted during CLR SHALL restart the sweep from id 0.

Verification
REQ-033 Sweep: N=8, W=8, release rst -> cmd_rdy=0 for 8 cycles, then 1; QUERY id 5 -> 4 cycles later status_vld_r=1, status_qry_r=1, status_id_r=5, status_dat_r=0x00.
REQ-034 Back-to-back INCR, SAT_EN=0: INIT id3=0xFE, then INCR id3 on each of the next 3 cycles -> dat 0xFE, 0xFF, 0x00 with ovf=1, then 0x01.
REQ-035 Back-to-back INCR, SAT_EN=1: same sequence as REQ-034 -> dat 0xFE, 0xFF, 0xFF with ovf=1, then 0xFF with ovf=1.
REQ-036 Underflow: DECR on id 0 holding 0 -> SAT_EN=0 gives 0xFF with ovf=1; SAT_EN=1 gives 0x00 with ovf=1.
REQ-037 Interleaved forwarding: ADD id1 0x80, ADD id2 0x10, ADD id1 0x90, RDCLR id1, QUERY id1 -> dat 0x80, 0x10, 0x10 with ovf=1 (wrap), 0x10, 0x00.
REQ-038 Mid-stream reset: pulse rst with 3 INCR id4 in flight -> status_vld_r=0 the next cycle, the sweep reruns, and a later QUERY id4 -> 0x00.
